// File: rtl/salamander_prom_loader_if.sv
// ---------------------------------------------------------------------------
// salamander_prom_loader_if
// Bundles the HPS ioctl download stream and the PROM programming bus used by
// salamander_prom_loader.
//   i_IOCTL_DOWNLOAD / i_IOCTL_INDEX / i_IOCTL_ADDR / i_IOCTL_DATA / i_IOCTL_WR
//     : download stream from the ioctl source (one byte per i_IOCTL_WR pulse)
//   o_IOCTL_WAIT : back-pressure to the ioctl source
//   o_PROG_ADDR / o_PROG_DIN / o_PROG_CS / o_PROG_WR
//     : shared PROM programming bus with one-hot chip selects
//   o_LOAD_DONE / o_CSUM / o_DROP : load status
// Modports: slave = the loader, master = the ioctl source / PROM bank side.
// ---------------------------------------------------------------------------
interface salamander_prom_loader_if;
  logic        i_IOCTL_DOWNLOAD;
  logic [7:0]  i_IOCTL_INDEX;
  logic [24:0] i_IOCTL_ADDR;
  logic [7:0]  i_IOCTL_DATA;
  logic        i_IOCTL_WR;
  logic        o_IOCTL_WAIT;
  logic [15:0] o_PROG_ADDR;
  logic [7:0]  o_PROG_DIN;
  logic [3:0]  o_PROG_CS;
  logic        o_PROG_WR;
  logic        o_LOAD_DONE;
  logic [7:0]  o_CSUM;
  logic        o_DROP;

  modport slave (
    input  i_IOCTL_DOWNLOAD, i_IOCTL_INDEX, i_IOCTL_ADDR, i_IOCTL_DATA, i_IOCTL_WR,
    output o_IOCTL_WAIT, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
           o_LOAD_DONE, o_CSUM, o_DROP
  );

  modport master (
    output i_IOCTL_DOWNLOAD, i_IOCTL_INDEX, i_IOCTL_ADDR, i_IOCTL_DATA, i_IOCTL_WR,
    input  o_IOCTL_WAIT, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
           o_LOAD_DONE, o_CSUM, o_DROP
  );
endinterface

// File: rtl/salamander_prom_loader.sv
// ---------------------------------------------------------------------------
// salamander_prom_loader
// Converts the HPS ioctl download byte stream into PROM programming writes.
// Each accepted byte is decoded into one of four address regions; the write
// strobe is held for WR_HOLD cycles followed by one gap cycle so that PROMs
// sitting in another clock domain capture it safely.
// Ports:
//   i_MCLK  : system clock, rising edge
//   i_RST_n : asynchronous active-low reset
//   io      : salamander_prom_loader_if.slave (ioctl stream in, PROM bus and
//             status out)
// WR_HOLD must lie in 1..15 (hold counter is 4 bits wide).
// ---------------------------------------------------------------------------
module salamander_prom_loader #(
  parameter logic [7:0]  DL_INDEX = 8'd0,
  parameter int          WR_HOLD  = 2,
  parameter logic [24:0] R0_BASE  = 25'h000000,
  parameter int          R0_AW    = 8,
  parameter logic [24:0] R1_BASE  = 25'h000100,
  parameter int          R1_AW    = 8,
  parameter logic [24:0] R2_BASE  = 25'h000200,
  parameter int          R2_AW    = 8,
  parameter logic [24:0] R3_BASE  = 25'h000300,
  parameter int          R3_AW    = 10
) (
  input logic                      i_MCLK,
  input logic                      i_RST_n,
  salamander_prom_loader_if.slave  io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD - 1);

  // 26-bit compare so that a region ending exactly at 2**25 does not wrap.
  function automatic logic in_region(input logic [24:0] a,
                                     input logic [24:0] base,
                                     input int          aw);
    logic [25:0] lo;
    logic [25:0] hi;
    lo = {1'b0, base};
    hi = lo + (26'd1 << aw);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic [15:0] rel_addr(input logic [24:0] a,
                                           input logic [24:0] base,
                                           input int          aw);
    logic [24:0] d;
    logic [24:0] m;
    d = a - base;
    m = (25'd1 << aw) - 25'd1;
    return 16'(d & m);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] addr_q,  addr_d;
  logic [7:0]  din_q,   din_d;
  logic [3:0]  cs_q,    cs_d;
  logic [7:0]  csum_q,  csum_d;
  logic        done_q,  done_d;
  logic        drop_q,  drop_d;
  logic        end_q,   end_d;

  logic [3:0]  dec_cs;
  logic [15:0] dec_addr;

  // Region decode of the live byte address; lowest region index wins.
  always_comb begin
    dec_cs   = 4'b0000;
    dec_addr = 16'h0000;
    if (in_region(io.i_IOCTL_ADDR, R0_BASE, R0_AW)) begin
      dec_cs   = 4'b0001;
      dec_addr = rel_addr(io.i_IOCTL_ADDR, R0_BASE, R0_AW);
    end else if (in_region(io.i_IOCTL_ADDR, R1_BASE, R1_AW)) begin
      dec_cs   = 4'b0010;
      dec_addr = rel_addr(io.i_IOCTL_ADDR, R1_BASE, R1_AW);
    end else if (in_region(io.i_IOCTL_ADDR, R2_BASE, R2_AW)) begin
      dec_cs   = 4'b0100;
      dec_addr = rel_addr(io.i_IOCTL_ADDR, R2_BASE, R2_AW);
    end else if (in_region(io.i_IOCTL_ADDR, R3_BASE, R3_AW)) begin
      dec_cs   = 4'b1000;
      dec_addr = rel_addr(io.i_IOCTL_ADDR, R3_BASE, R3_AW);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cs_d    = cs_q;
    csum_d  = csum_q;
    done_d  = done_q;
    drop_d  = drop_q;
    end_d   = end_q;

    unique case (state_q)
      S_IDLE: begin
        // Index is only qualified here; later index changes are ignored.
        if (io.i_IOCTL_DOWNLOAD && (io.i_IOCTL_INDEX == DL_INDEX)) begin
          state_d = S_ARMED;
          done_d  = 1'b0;
          csum_d  = 8'h00;
          drop_d  = 1'b0;
        end
      end

      S_ARMED: begin
        // A strobe coinciding with download end is still taken; the end is
        // remembered and honoured after the gap cycle.
        if (io.i_IOCTL_WR) begin
          state_d = S_HOLD;
          cnt_d   = 4'd0;
          addr_d  = dec_addr;
          din_d   = io.i_IOCTL_DATA;
          cs_d    = dec_cs;
          end_d   = ~io.i_IOCTL_DOWNLOAD;
        end else if (!io.i_IOCTL_DOWNLOAD) begin
          state_d = S_DONE;
        end
      end

      S_HOLD: begin
        if (!io.i_IOCTL_DOWNLOAD) end_d = 1'b1;
        if (io.i_IOCTL_WR)        drop_d = 1'b1;
        if ((cnt_q == 4'd0) && (cs_q != 4'b0000)) csum_d = csum_q + din_q;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_GAP: begin
        if (io.i_IOCTL_WR) drop_d = 1'b1;
        if (end_q || !io.i_IOCTL_DOWNLOAD) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ARMED;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Done flag must already be visible during the DONE cycle itself.
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      din_q   <= 8'h00;
      cs_q    <= 4'b0000;
      csum_q  <= 8'h00;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cs_q    <= cs_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      end_q   <= end_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them
  // asynchronously and nothing toggles mid-cycle.
  assign io.o_IOCTL_WAIT = (state_q == S_HOLD) || (state_q == S_GAP);
  assign io.o_PROG_WR    = (state_q == S_HOLD) && (cs_q != 4'b0000);
  assign io.o_PROG_CS    = ((state_q == S_HOLD) || (state_q == S_GAP)) ? cs_q : 4'b0000;
  assign io.o_PROG_ADDR  = addr_q;
  assign io.o_PROG_DIN   = din_q;
  assign io.o_LOAD_DONE  = done_q;
  assign io.o_CSUM       = csum_q;
  assign io.o_DROP       = drop_q;

endmodule
